rw_word_responder: RTL and testbench

//  Memory-side responder for the 16-bit write/read strobe interface driven by the
//  AES block-processing masters. Accepts single-cycle write strobes into a circular

---
 rtl/rw_word_responder.sv | 179 +++++++++++++++++
 tb/tb_rw_word_responder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rw_word_responder.sv
// rw_word_responder
//   Memory-side responder for a 16-bit write/read strobe interface. Writes go
//   into a circular word buffer; reads return buffered words in FIFO order with
//   one cycle of latency. The block also tracks how many full cipher blocks
//   have been accepted and signals when at least one block is buffered.
//
// Ports
//   iCLK        clock, all logic on the rising edge
//   iRST        asynchronous reset, active-high
//   write       write strobe, one word per high cycle
//   writedata   word accompanying write
//   read        read strobe, one word per high cycle
//   readdata    registered read word; holds until the next accepted read
//   oRD_VALID   one-cycle pulse, readdata was updated by the previous strobe
//   oLEVEL      words currently stored (0..2^DEPTH_LOG2)
//   oFULL       oLEVEL == 2^DEPTH_LOG2
//   oEMPTY      oLEVEL == 0
//   oBLOCK_RDY  at least BLOCK_WORDS words stored
//   oBLOCK_CNT  number of BLOCK_WORDS-word groups accepted, wraps at 16 bits
//   oOVF        sticky: write arrived while full without a read
//   oUNF        sticky: read arrived while empty
//   iCLR_ERR    synchronous clear of oOVF/oUNF (a same-cycle error wins)
module rw_word_responder #(
    parameter int DATA_W      = 16,
    parameter int DEPTH_LOG2  = 6,
    parameter int BLOCK_WORDS = 8
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic                  write,
    input  logic [DATA_W-1:0]     writedata,
    input  logic                  read,
    output logic [DATA_W-1:0]     readdata,
    output logic                  oRD_VALID,
    output logic [DEPTH_LOG2:0]   oLEVEL,
    output logic                  oFULL,
    output logic                  oEMPTY,
    output logic                  oBLOCK_RDY,
    output logic [15:0]           oBLOCK_CNT,
    output logic                  oOVF,
    output logic                  oUNF,
    input  logic                  iCLR_ERR
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;
    localparam int BW    = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

    localparam logic [LW-1:0] LVL_MAX  = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_BLK  = LW'(BLOCK_WORDS);
    localparam logic [BW-1:0] WIB_LAST = BW'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_BLOCK,
        ST_FULL
    } state_t;

    // Buffer storage, deliberately not reset
    logic [DATA_W-1:0] mem [DEPTH];

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q,  level_d;
    logic [BW-1:0]     wib_q,    wib_d;
    logic [15:0]       bcnt_q,   bcnt_d;
    logic              ovf_q,    ovf_d;
    logic              unf_q,    unf_d;
    logic              valid_q,  valid_d;
    logic [DATA_W-1:0] rdata_q;
    state_t            state_q,  state_d;

    logic              empty;
    logic              full;
    logic              rd_acc;
    logic              wr_acc;

    assign empty = (level_q == '0);
    assign full  = (level_q == LVL_MAX);

    // A write into a full buffer is still accepted when a read frees a slot on
    // the same edge. An empty buffer never bypasses: the read is rejected even
    // if a write lands in the same cycle.
    assign rd_acc = read && !empty;
    assign wr_acc = write && (!full || rd_acc);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        wib_d    = wib_q;
        bcnt_d   = bcnt_q;
        valid_d  = rd_acc;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (wib_q == WIB_LAST) begin
                wib_d  = '0;
                bcnt_d = bcnt_q + 16'd1;
            end else begin
                wib_d  = wib_q + BW'(1);
            end
        end

        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        unique case ({wr_acc, rd_acc})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // Sticky errors: clear first, then a same-cycle error sets again
        ovf_d = ovf_q && !iCLR_ERR;
        unf_d = unf_q && !iCLR_ERR;
        if (write && !wr_acc) ovf_d = 1'b1;
        if (read && !rd_acc)  unf_d = 1'b1;

        // Block-tracking state follows the level that will be stored this edge
        if (level_d == '0) begin
            state_d = ST_IDLE;
        end else if (level_d == LVL_MAX) begin
            state_d = ST_FULL;
        end else if (level_d >= LVL_BLK) begin
            state_d = ST_BLOCK;
        end else begin
            state_d = ST_FILL;
        end
    end

    always_ff @(posedge iCLK) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= writedata;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            wib_q    <= '0;
            bcnt_q   <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            valid_q  <= 1'b0;
            rdata_q  <= '0;
            state_q  <= ST_IDLE;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            wib_q    <= wib_d;
            bcnt_q   <= bcnt_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            valid_q  <= valid_d;
            state_q  <= state_d;
            if (rd_acc) begin
                rdata_q <= mem[rd_ptr_q];
            end
        end
    end

    assign readdata   = rdata_q;
    assign oRD_VALID  = valid_q;
    assign oLEVEL     = level_q;
    assign oFULL      = full;
    assign oEMPTY     = empty;
    assign oBLOCK_RDY = (state_q == ST_BLOCK) || (state_q == ST_FULL);
    assign oBLOCK_CNT = bcnt_q;
    assign oOVF       = ovf_q;
    assign oUNF       = unf_q;

endmodule

// File: tb/tb_rw_word_responder.sv
// Testbench for rw_word_responder: directed scenarios followed by randomized
// traffic, all checked against a queue-based reference model. Read data is
// checked by a separate monitor against a scoreboard of expected words.
module tb_rw_word_responder;

    localparam int DEPTH = 64;
    localparam int BLK   = 8;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        write = 1'b0;
    logic [15:0] writedata = '0;
    logic        read = 1'b0;
    logic [15:0] readdata;
    logic        oRD_VALID;
    logic [6:0]  oLEVEL;
    logic        oFULL;
    logic        oEMPTY;
    logic        oBLOCK_RDY;
    logic [15:0] oBLOCK_CNT;
    logic        oOVF;
    logic        oUNF;
    logic        iCLR_ERR = 1'b0;

    rw_word_responder #(
        .DATA_W      (16),
        .DEPTH_LOG2  (6),
        .BLOCK_WORDS (8)
    ) dut (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .write      (write),
        .writedata  (writedata),
        .read       (read),
        .readdata   (readdata),
        .oRD_VALID  (oRD_VALID),
        .oLEVEL     (oLEVEL),
        .oFULL      (oFULL),
        .oEMPTY     (oEMPTY),
        .oBLOCK_RDY (oBLOCK_RDY),
        .oBLOCK_CNT (oBLOCK_CNT),
        .oOVF       (oOVF),
        .oUNF       (oUNF),
        .iCLR_ERR   (iCLR_ERR)
    );

    always #5 iCLK = ~iCLK;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] mq[$];
    logic [15:0] sb[$];
    logic [15:0] m_rd;
    bit          m_valid;
    int          m_wib;
    int          m_bcnt;
    bit          m_ovf;
    bit          m_unf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        sb.delete();
        m_rd    = '0;
        m_valid = 1'b0;
        m_wib   = 0;
        m_bcnt  = 0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    task automatic check_status(input string tag);
        chk({tag, ".readdata"}, 32'(readdata), 32'(m_rd));
        chk({tag, ".rd_valid"}, 32'(oRD_VALID), 32'(m_valid));
        chk({tag, ".level"}, 32'(oLEVEL), 32'(mq.size()));
        chk({tag, ".full"}, 32'(oFULL), 32'(mq.size() == DEPTH));
        chk({tag, ".empty"}, 32'(oEMPTY), 32'(mq.size() == 0));
        chk({tag, ".block_rdy"}, 32'(oBLOCK_RDY), 32'(mq.size() >= BLK));
        chk({tag, ".block_cnt"}, 32'(oBLOCK_CNT), 32'(m_bcnt));
        chk({tag, ".ovf"}, 32'(oOVF), 32'(m_ovf));
        chk({tag, ".unf"}, 32'(oUNF), 32'(m_unf));
    endtask

    // One clock of stimulus; called at posedge+1, returns at the next posedge+1
    task automatic cycle(input bit w, input logic [15:0] d, input bit r, input bit c);
        bit ra;
        bit wa;
        write     = w;
        writedata = d;
        read      = r;
        iCLR_ERR  = c;
        ra = r && (mq.size() > 0);
        wa = w && ((mq.size() < DEPTH) || ra);
        m_valid = ra;
        if (ra) begin
            m_rd = mq.pop_front();
            sb.push_back(m_rd);
        end
        if (wa) begin
            mq.push_back(d);
            m_wib++;
            if (m_wib == BLK) begin
                m_wib  = 0;
                m_bcnt = (m_bcnt + 1) & 16'hFFFF;
            end
        end
        if (c) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (w && !wa) m_ovf = 1'b1;
        if (r && !ra) m_unf = 1'b1;
        @(posedge iCLK);
        #1;
        write    = 1'b0;
        read     = 1'b0;
        iCLR_ERR = 1'b0;
        check_status("cyc");
    endtask

    // Asserted between edges so the asynchronous clear is observed without a clock
    task automatic async_reset();
        write    = 1'b0;
        read     = 1'b0;
        iCLR_ERR = 1'b0;
        #2;
        iRST = 1'b1;
        #1;
        model_reset();
        check_status("rst");
        @(negedge iCLK);
        iRST = 1'b0;
        @(posedge iCLK);
        #1;
        check_status("post_rst");
    endtask

    // Monitor: every read-valid pulse must match the oldest expected word
    always @(negedge iCLK) begin
        if (!iRST && oRD_VALID) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected at %0t: got 0x%0h expected no read", $time, readdata);
            end else begin
                logic [15:0] e;
                e = sb.pop_front();
                if (readdata !== e) begin
                    errors++;
                    $display("FAIL sb_data at %0t: got 0x%0h expected 0x%0h", $time, readdata, e);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog at %0t: got timeout expected completion", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        @(posedge iCLK);
        #1;
        async_reset();

        // Eight words form one block, then drain in order
        for (int i = 1; i <= 8; i++) cycle(1'b1, 16'(i), 1'b0, 1'b0);
        chk("blk8.level", 32'(oLEVEL), 32'd8);
        chk("blk8.rdy", 32'(oBLOCK_RDY), 32'd1);
        chk("blk8.cnt", 32'(oBLOCK_CNT), 32'd1);
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        chk("blk8.last", 32'(readdata), 32'h0008);
        cycle(1'b0, '0, 1'b0, 1'b0);

        // Fill completely, then overflow with a dropped word
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0);
        cycle(1'b1, 16'hDEAD, 1'b0, 1'b0);
        chk("ovf.full", 32'(oFULL), 32'd1);
        chk("ovf.flag", 32'(oOVF), 32'd1);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        chk("ovf.empty", 32'(oEMPTY), 32'd1);
        cycle(1'b0, '0, 1'b0, 1'b1);

        // Underflow keeps the last read word
        cycle(1'b1, 16'h1234, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("unf.hold", 32'(readdata), 32'h1234);
        chk("unf.flag", 32'(oUNF), 32'd1);
        cycle(1'b0, '0, 1'b0, 1'b1);
        chk("unf.clr", 32'(oUNF), 32'd0);

        // Simultaneous read+write while full, BEEF comes out 64th
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 16'(16'h2000 + i), 1'b0, 1'b0);
        cycle(1'b1, 16'hBEEF, 1'b1, 1'b0);
        chk("fullrw.level", 32'(oLEVEL), 32'd64);
        chk("fullrw.ovf", 32'(oOVF), 32'd0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        chk("fullrw.beef", 32'(readdata), 32'hBEEF);

        // Simultaneous read+write while empty: write stored, read rejected
        cycle(1'b1, 16'h00AA, 1'b1, 1'b0);
        chk("emptyrw.level", 32'(oLEVEL), 32'd1);
        chk("emptyrw.unf", 32'(oUNF), 32'd1);
        cycle(1'b0, '0, 1'b1, 1'b1);
        chk("emptyrw.data", 32'(readdata), 32'h00AA);

        // Reset mid-block discards partial progress
        for (int i = 0; i < 5; i++) cycle(1'b1, 16'(16'h3000 + i), 1'b0, 1'b0);
        async_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 16'(16'h4000 + i), 1'b0, 1'b0);
        chk("rst.blkcnt", 32'(oBLOCK_CNT), 32'd1);
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        chk("rst.first", 32'(readdata), 32'h4007);

        // Randomized traffic with phases biased toward filling or draining
        for (int ph = 0; ph < 16; ph++) begin
            int pw;
            int pr;
            pw = (ph % 3 == 0) ? 85 : (ph % 3 == 1) ? 20 : 55;
            pr = (ph % 3 == 0) ? 25 : (ph % 3 == 1) ? 85 : 55;
            for (int k = 0; k < 200; k++) begin
                if ($urandom_range(0, 999) == 0) begin
                    async_reset();
                end else begin
                    cycle($urandom_range(0, 99) < pw, 16'($urandom),
                          $urandom_range(0, 99) < pr, $urandom_range(0, 19) == 0);
                end
            end
        end

        // Drain anything left and let the monitor catch up
        while (mq.size() > 0) cycle(1'b0, '0, 1'b1, 1'b0);
        @(negedge iCLK);
        @(negedge iCLK);
        chk("sb.drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
